ol_dpwm: RTL and testbench

- Open-loop digital PWM stage that consumes the 11-bit on-time word from the duty-select lookup and drives the converter's gate signal.
- A free-running period counter is compared against a shadow on-time register.
- The shadow loads only at period boundaries, so duty changes never glitch mid-period.
- Sits between the duty-select lookup and the gate-driver pins; emits a per-period sync strobe for ADC/telemetry timing.

---
 rtl/ol_dpwm_pkg.sv | 22 ++
 rtl/ol_dpwm_cnt.sv | 35 +++
 rtl/ol_dpwm.sv | 165 ++++++++++++++++
 tb/tb_ol_dpwm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ol_dpwm_pkg.sv
// -----------------------------------------------------------------------------
// ol_dpwm_pkg
// Shared definitions for the open-loop DPWM stage and the duty-select lookup
// that feeds it.
//   state_t      : FSM state encoding (IDLE, RUN, DRAIN)
//   TON_W        : width of the on-time word and of the period counter
//   *_DEF        : default switching period, minimum off-time and dead-time
// -----------------------------------------------------------------------------
package ol_dpwm_pkg;

  localparam int TON_W       = 11;
  localparam int PERIOD_DEF  = 1000;
  localparam int MIN_OFF_DEF = 4;
  localparam int DT_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ol_dpwm_cnt.sv
// -----------------------------------------------------------------------------
// ol_dpwm_cnt
// Free-running period counter, 0..PERIOD-1, advancing only while enabled.
// Ports:
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset (counter to 0)
//   i_en    : count enable; counter holds when low
//   o_cnt   : current count
//   o_wrap  : high while o_cnt == PERIOD-1 (the next enabled edge wraps to 0)
// -----------------------------------------------------------------------------
module ol_dpwm_cnt
  import ol_dpwm_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [TON_W-1:0] o_cnt,
  output logic             o_wrap
);

  localparam logic [TON_W-1:0] LAST = TON_W'(PERIOD - 1);

  assign o_wrap = (o_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_wrap ? '0 : o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ol_dpwm.sv
// -----------------------------------------------------------------------------
// ol_dpwm
// Open-loop digital PWM stage. A period counter is compared against a shadow
// on-time register that reloads only at period boundaries, so duty changes
// never produce a partial pulse.
// Optional build macro: OL_DPWM_DEADTIME_EN enables the low-side gate output
// with dead-time on both edges; without it o_pwm_l is tied low.
// Ports:
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset
//   i_en     : run request (level)
//   i_ton    : requested on-time in cycles
//   o_pwm    : high-side gate drive (registered)
//   o_pwm_l  : low-side gate drive (registered, 0 unless dead-time build)
//   o_sync   : one-cycle pulse on the first cycle of each period
//   o_ton_ld : one-cycle pulse on the cycle the shadow register takes a value
//   o_busy   : high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module ol_dpwm
  import ol_dpwm_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,
  parameter int MIN_OFF = MIN_OFF_DEF,
  parameter int DT      = DT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [TON_W-1:0] i_ton,
  output logic             o_pwm,
  output logic             o_pwm_l,
  output logic             o_sync,
  output logic             o_ton_ld,
  output logic             o_busy
);

  // Reject configurations where the counter overflows TON_W bits or the
  // clamp limit would go negative.
  if (PERIOD < 2 || PERIOD > 2047 || MIN_OFF + 2 * DT >= PERIOD) begin : g_bad_cfg
    $error("ol_dpwm: illegal PERIOD/MIN_OFF/DT combination");
  end

`ifdef OL_DPWM_DEADTIME_EN
  localparam int TON_MAX_I = PERIOD - MIN_OFF - 2 * DT;
`else
  localparam int TON_MAX_I = PERIOD - MIN_OFF;
`endif
  localparam logic [TON_W-1:0] TON_MAX = TON_W'(TON_MAX_I);

  // Saturate the requested on-time so the minimum off-time always survives.
  function automatic logic [TON_W-1:0] clamp_ton(input logic [TON_W-1:0] ton);
    return (ton > TON_MAX) ? TON_MAX : ton;
  endfunction

  state_t           state, state_nxt;
  logic             load;
  logic             cnt_en;
  logic             wrap;
  logic [TON_W-1:0] cnt;
  logic [TON_W-1:0] ton_c;
  logic [TON_W-1:0] ton_sh;
  logic             pwm_p1;
  logic             sync_p1;
  logic             ton_ld_p1;
  logic             busy_p1;

  assign ton_c  = clamp_ton(i_ton);
  assign cnt_en = (state != IDLE);

  ol_dpwm_cnt #(
    .PERIOD (PERIOD)
  ) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (cnt_en),
    .o_cnt  (cnt),
    .o_wrap (wrap)
  );

  // Next state and shadow-load decision. A shadow load always coincides with
  // cnt becoming 0, so the new on-time governs a whole period.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (i_en) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        // The wrap load happens even when the run request drops on the same
        // cycle; DRAIN then covers a full period with gates low.
        load = wrap;
        if (!i_en) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (wrap) begin
          if (i_en) begin
            state_nxt = RUN;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: state/shadow update and registered compare outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ton_sh    <= '0;
      pwm_p1    <= 1'b0;
      sync_p1   <= 1'b0;
      ton_ld_p1 <= 1'b0;
      busy_p1   <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (load) begin
        ton_sh <= ton_c;
      end
      pwm_p1    <= (state == RUN) && (cnt < ton_sh);
      sync_p1   <= (state == RUN) && (cnt == '0);
      ton_ld_p1 <= load;
      busy_p1   <= (state_nxt != IDLE);
    end
  end

`ifdef OL_DPWM_DEADTIME_EN
  // One extra bit so ton_sh + DT cannot wrap around.
  localparam int              CMP_W  = TON_W + 1;
  localparam logic [CMP_W-1:0] LO_END = CMP_W'(PERIOD - DT);

  logic [CMP_W-1:0] lo_start;
  logic             pwm_l_p1;

  assign lo_start = {1'b0, ton_sh} + CMP_W'(DT);

  // Stage p0 -> p1: low-side gate with dead-time after the high-side pulse
  // and before the next period's rising edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pwm_l_p1 <= 1'b0;
    end else begin
      pwm_l_p1 <= (state == RUN) && ({1'b0, cnt} >= lo_start) && ({1'b0, cnt} < LO_END);
    end
  end

  assign o_pwm_l = pwm_l_p1;
`else
  assign o_pwm_l = 1'b0;
`endif

  assign o_pwm    = pwm_p1;
  assign o_sync   = sync_p1;
  assign o_ton_ld = ton_ld_p1;
  assign o_busy   = busy_p1;

endmodule

// File: tb/tb_ol_dpwm.sv
// -----------------------------------------------------------------------------
// tb_ol_dpwm
// Self-checking bench for ol_dpwm: a cycle-level behavioural model of the
// period/shadow/drain rules predicts every output each cycle, and directed
// pulse-width, period and drain-length measurements pin the model to
// hand-computed numbers. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_ol_dpwm;

  localparam int PERIOD  = 1000;
  localparam int MIN_OFF = 4;
  localparam int DT      = 8;
`ifdef OL_DPWM_DEADTIME_EN
  localparam int TON_MAX = PERIOD - MIN_OFF - 2 * DT;
`else
  localparam int TON_MAX = PERIOD - MIN_OFF;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic [10:0] i_ton = 11'd0;
  logic        o_pwm, o_pwm_l, o_sync, o_ton_ld, o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;

  always #5 clk = ~clk;

  ol_dpwm #(
    .PERIOD  (PERIOD),
    .MIN_OFF (MIN_OFF),
    .DT      (DT)
  ) u_dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_ton    (i_ton),
    .o_pwm    (o_pwm),
    .o_pwm_l  (o_pwm_l),
    .o_sync   (o_sync),
    .o_ton_ld (o_ton_ld),
    .o_busy   (o_busy)
  );

  // Behavioural model: mode 0 = idle, 1 = running, 2 = draining.
  int       m_mode = 0;
  int       m_cnt  = 0;
  int       m_sh   = 0;
  bit       m_valid = 1'b0;
  logic [4:0] exp_o = 5'b0;
  bit       m_run, m_wrap, m_ld, m_pwm, m_pwml, m_sync;
  int       m_next;

  always @(posedge clk) begin
    if (i_rst) begin
      m_mode  = 0;
      m_cnt   = 0;
      m_sh    = 0;
      exp_o   = 5'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_run  = (m_mode == 1);
      m_wrap = (m_cnt == PERIOD - 1);
      m_pwm  = m_run && (m_cnt < m_sh);
      m_sync = m_run && (m_cnt == 0);
`ifdef OL_DPWM_DEADTIME_EN
      m_pwml = m_run && (m_cnt >= m_sh + DT) && (m_cnt < PERIOD - DT);
`else
      m_pwml = 1'b0;
`endif
      m_ld   = 1'b0;
      m_next = m_mode;
      if (m_mode == 0) begin
        if (i_en) begin m_next = 1; m_ld = 1'b1; end
      end else if (m_mode == 1) begin
        if (m_wrap) m_ld = 1'b1;
        if (!i_en) m_next = 2;
      end else if (m_wrap) begin
        if (i_en) begin m_next = 1; m_ld = 1'b1; end
        else m_next = 0;
      end
      m_cnt = (m_mode == 0 || m_wrap) ? 0 : m_cnt + 1;
      if (m_ld) m_sh = (int'(i_ton) > TON_MAX) ? TON_MAX : int'(i_ton);
      m_mode = m_next;
      exp_o  = {m_pwm, m_pwml, m_sync, m_ld, (m_next != 0)};
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      n_tests++;
      if ({o_pwm, o_pwm_l, o_sync, o_ton_ld, o_busy} !== exp_o || (o_pwm && o_pwm_l)) begin
        n_fail++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL cycle @%0t {pwm,pwm_l,sync,ton_ld,busy} got=%b required=%b",
                   $time, {o_pwm, o_pwm_l, o_sync, o_ton_ld, o_busy}, exp_o);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_sync();
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (o_sync) return;
    end
    timeout_fail("wait_sync");
  endtask

  // Starting on an o_sync cycle, runs to the next o_sync. Offsets k are
  // cycles after the sync cycle (counter value k+1 during that cycle).
  task automatic measure(input int ton_at, input int ton_val, input int off_at,
                         input int on_at, output int highs, output int per,
                         output int busy_low);
    highs = 0; per = 0; busy_low = 0;
    for (int k = 0; k < 2100; k++) begin
      highs    += int'(o_pwm);
      busy_low += int'(!o_busy);
      if (k == ton_at) i_ton = 11'(ton_val);
      if (k == off_at) i_en = 1'b0;
      if (k == on_at)  i_en = 1'b1;
      @(negedge clk);
      per = k + 1;
      if (o_sync) return;
    end
    timeout_fail("measure");
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int h, p, b, busy_n, late, ldn;

    repeat (3) @(negedge clk);
    check("rst_pwm",    int'(o_pwm),    0);
    check("rst_sync",   int'(o_sync),   0);
    check("rst_busy",   int'(o_busy),   0);
    check("rst_ton_ld", int'(o_ton_ld), 0);
    i_rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(o_busy), 0);

    // Start from idle with 251.
    i_en = 1'b1; i_ton = 11'd251;
    @(negedge clk);
    check("start_ton_ld", int'(o_ton_ld), 1);
    check("start_busy",   int'(o_busy),   1);
    wait_sync();
    measure(299, 502, -1, -1, h, p, b);
    check("ton251_high",   h, 251);
    check("ton251_period", p, 1000);
    measure(-1, 0, -1, -1, h, p, b);
    check("ton502_high",   h, 502);
    check("ton502_period", p, 1000);

    // Zero on-time: no pulse, sync keeps running.
    i_ton = 11'd0;
    measure(-1, 0, -1, -1, h, p, b);
    measure(-1, 0, -1, -1, h, p, b);
    check("ton0_high",   h, 0);
    check("ton0_period", p, 1000);

    // Over-range request clamps.
    i_ton = 11'd2000;
    measure(-1, 0, -1, -1, h, p, b);
    measure(-1, 0, -1, -1, h, p, b);
    check("ton2000_high",   h, TON_MAX);
    check("ton2000_period", p, 1000);
    check("ton2000_busy",   b, 0);

    // Drop the run request at cnt=100 with ton=400.
    i_ton = 11'd400;
    measure(-1, 0, -1, -1, h, p, b);
    repeat (99) @(negedge clk);
    i_en = 1'b0;
    busy_n = 0; late = 0;
    for (int k = 0; k < 2100; k++) begin
      if (!o_busy) break;
      busy_n++;
      if (k >= 2) late += int'(o_pwm);
      @(negedge clk);
    end
    check("drain_busy_cycles", busy_n, 900);
    check("drain_pwm_late",    late,   0);
    check("drain_idle_pwm",    int'(o_pwm), 0);

    // Reset in the middle of a pulse.
    i_en = 1'b1;
    wait_sync();
    repeat (49) @(negedge clk);
    check("prerst_pwm", int'(o_pwm), 1);
    i_rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm",    int'(o_pwm),    0);
    check("midrst_sync",   int'(o_sync),   0);
    check("midrst_busy",   int'(o_busy),   0);
    check("midrst_ton_ld", int'(o_ton_ld), 0);
    check("midrst_ton_sh", int'(u_dut.ton_sh), 0);
    i_rst = 1'b0; i_en = 1'b0;
    @(negedge clk);
    check("postrst_busy", int'(o_busy), 0);

    // Run request falls on the wrap cycle: load still happens, full drain.
    i_ton = 11'd123; i_en = 1'b1;
    wait_sync();
    repeat (998) @(negedge clk);
    i_en = 1'b0;
    busy_n = 0; ldn = 0;
    for (int k = 0; k < 2500; k++) begin
      if (!o_busy) break;
      busy_n++;
      ldn += int'(o_ton_ld);
      @(negedge clk);
    end
    check("wrapdrop_busy_cycles", busy_n, 1001);
    check("wrapdrop_loads",       ldn,    1);

    // Request returns during drain: resume straight into RUN at the wrap.
    i_ton = 11'd300; i_en = 1'b1;
    wait_sync();
    measure(-1, 0, 99, 499, h, p, b);
    check("resume_high",      h, 101);
    check("resume_period",    p, 1000);
    check("resume_busy_low",  b, 0);

    // Randomized phase.
    for (int c = 0; c < 25000; c++) begin
      @(negedge clk);
      i_rst = 1'b0;
      if ($urandom_range(0, 299) == 0)  i_en  = ~i_en;
      if ($urandom_range(0, 199) == 0)  i_ton = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 3999) == 0) i_rst = 1'b1;
    end
    @(negedge clk);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
